// File: rtl/mem_bus_ctrl_pkg.sv
// Shared definitions for the main-memory bus sequencer: default bus widths,
// the controller state encoding and a helper for the byte-offset width.
package mem_bus_ctrl_pkg;

  // Default address and data widths of the system memory bus.
  localparam int MBC_ADDR_WIDTH = 32;
  localparam int MBC_DATA_WIDTH = 32;

  // Controller states. The encoding is fixed because other blocks decode it.
  typedef enum logic [1:0] {
    MBC_IDLE   = 2'b00,
    MBC_ACCESS = 2'b01,
    MBC_RESP   = 2'b10
  } mbcState_e;

  // Number of low address bits that select a byte within one data word.
  // A request is aligned only when all of these bits are zero.
  function automatic int mbcOffsetBits(input int dataWidth);
    return $clog2(dataWidth / 8);
  endfunction

endpackage

// File: rtl/mem_bus_timeout.sv
// Watchdog counter for the memory bus sequencer. Counts the cycles an access
// spends waiting on memory and flags the last cycle it is allowed to wait.
// Only instantiated when MEM_BUS_TIMEOUT_EN is defined.
module mem_bus_timeout
  import mem_bus_ctrl_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 16
) (
  input  logic clk,
  input  logic reset,
  input  logic clear,
  input  logic count_en,
  output logic terminal
);

  localparam int CountWidth = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [CountWidth-1:0] LastWaitCount = CountWidth'(TIMEOUT_CYCLES - 1);
  localparam logic [CountWidth-1:0] CountCeiling  = CountWidth'(TIMEOUT_CYCLES);

  logic [CountWidth-1:0] count_q, count_d;

  // Clear on entry to an access, otherwise advance once per unanswered wait
  // cycle; the count saturates so it can never wrap back into range.
  always_comb begin
    count_d = count_q;
    if (clear) begin
      count_d = '0;
    end else if (count_en && (count_q != CountCeiling)) begin
      count_d = count_q + CountWidth'(1);
    end
  end

  // Wait-cycle counter register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign terminal = (count_q == LastWaitCount);

endmodule

// File: rtl/mem_bus_ctrl.sv
// Main-memory bus sequencer. Takes one granted request at a time, runs a
// chip-select / ready handshake to the memory array and returns a single-cycle
// response carrying read data or an error flag. Misaligned requests are
// answered with an error without touching memory.
// Optional feature macro: MEM_BUS_TIMEOUT_EN -- abort accesses that memory
// has not acknowledged within TIMEOUT_CYCLES cycles.
module mem_bus_ctrl
  import mem_bus_ctrl_pkg::*;
#(
  parameter int ADDR_WIDTH     = MBC_ADDR_WIDTH,
  parameter int DATA_WIDTH     = MBC_DATA_WIDTH,
  parameter int TIMEOUT_CYCLES = 16
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  flush,
  input  logic                  req_valid,
  input  logic [ADDR_WIDTH-1:0] req_addr,
  input  logic                  req_we,
  input  logic [DATA_WIDTH-1:0] req_wdata,
  output logic                  req_ready,
  output logic                  rsp_valid,
  output logic [DATA_WIDTH-1:0] rsp_rdata,
  output logic                  rsp_err,
  output logic                  mem_cs,
  output logic                  mem_we,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  output logic [DATA_WIDTH-1:0] mem_wdata,
  input  logic                  mem_ready,
  input  logic [DATA_WIDTH-1:0] mem_rdata
);

  localparam int OffsetBits = mbcOffsetBits(DATA_WIDTH);

  mbcState_e state_q, state_d;

  // Holding registers for the accepted request.
  logic [ADDR_WIDTH-1:0] holdAddr_q, holdAddr_d;
  logic                  holdWe_q, holdWe_d;
  logic [DATA_WIDTH-1:0] holdWdata_q, holdWdata_d;

  // Registered memory-side outputs.
  logic                  memCs_q, memCs_d;
  logic                  memWe_q, memWe_d;
  logic [ADDR_WIDTH-1:0] memAddr_q, memAddr_d;
  logic [DATA_WIDTH-1:0] memWdata_q, memWdata_d;

  // Registered response outputs.
  logic                  rspValid_q, rspValid_d;
  logic [DATA_WIDTH-1:0] rspRdata_q, rspRdata_d;
  logic                  rspErr_q, rspErr_d;

  logic accept;
  logic misaligned;
  logic startAccess;
  logic timeoutHit;

  // A new request may only be taken while idle, and never in a cycle that is
  // being flushed or reset, so flush always wins over a simultaneous request.
  assign req_ready   = (state_q == MBC_IDLE) && !flush && !reset;
  assign accept      = req_valid && req_ready;
  assign misaligned  = (req_addr[OffsetBits-1:0] != '0);
  assign startAccess = accept && !misaligned;

`ifdef MEM_BUS_TIMEOUT_EN
  logic countEn;

  // Only cycles spent in ACCESS without an acknowledge count as waiting.
  assign countEn = (state_q == MBC_ACCESS) && !mem_ready;

  mem_bus_timeout #(
    .TIMEOUT_CYCLES (TIMEOUT_CYCLES)
  ) uTimeout (
    .clk      (clk),
    .reset    (reset),
    .clear    (startAccess),
    .count_en (countEn),
    .terminal (timeoutHit)
  );
`else
  assign timeoutHit = 1'b0;
`endif

  // Next-state logic; output registers are loaded from the state being
  // entered so every mem_* and rsp_* pin comes straight from a flop.
  always_comb begin
    state_d     = state_q;
    holdAddr_d  = holdAddr_q;
    holdWe_d    = holdWe_q;
    holdWdata_d = holdWdata_q;
    rspRdata_d  = '0;
    rspErr_d    = 1'b0;

    case (state_q)
      MBC_IDLE: begin
        if (accept) begin
          holdAddr_d  = req_addr;
          holdWe_d    = req_we;
          holdWdata_d = req_wdata;
          if (misaligned) begin
            state_d  = MBC_RESP;
            rspErr_d = 1'b1;
          end else begin
            state_d = MBC_ACCESS;
          end
        end
      end
      MBC_ACCESS: begin
        if (mem_ready) begin
          state_d    = MBC_RESP;
          rspRdata_d = holdWe_q ? '0 : mem_rdata;
        end else if (timeoutHit) begin
          state_d  = MBC_RESP;
          rspErr_d = 1'b1;
        end
      end
      MBC_RESP: begin
        state_d = MBC_IDLE;
      end
      default: begin
        state_d = MBC_IDLE;
      end
    endcase

    if (flush) begin
      state_d    = MBC_IDLE;
      rspRdata_d = '0;
      rspErr_d   = 1'b0;
    end

    memCs_d    = (state_d == MBC_ACCESS);
    memWe_d    = memCs_d ? holdWe_d : 1'b0;
    memAddr_d  = memCs_d ? holdAddr_d : '0;
    memWdata_d = memCs_d ? holdWdata_d : '0;
    rspValid_d = (state_d == MBC_RESP);
  end

  // State, holding and output registers; reset drops everything at once,
  // including an in-flight chip select.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= MBC_IDLE;
      holdAddr_q  <= '0;
      holdWe_q    <= 1'b0;
      holdWdata_q <= '0;
      memCs_q     <= 1'b0;
      memWe_q     <= 1'b0;
      memAddr_q   <= '0;
      memWdata_q  <= '0;
      rspValid_q  <= 1'b0;
      rspRdata_q  <= '0;
      rspErr_q    <= 1'b0;
    end else begin
      state_q     <= state_d;
      holdAddr_q  <= holdAddr_d;
      holdWe_q    <= holdWe_d;
      holdWdata_q <= holdWdata_d;
      memCs_q     <= memCs_d;
      memWe_q     <= memWe_d;
      memAddr_q   <= memAddr_d;
      memWdata_q  <= memWdata_d;
      rspValid_q  <= rspValid_d;
      rspRdata_q  <= rspRdata_d;
      rspErr_q    <= rspErr_d;
    end
  end

  assign mem_cs    = memCs_q;
  assign mem_we    = memWe_q;
  assign mem_addr  = memAddr_q;
  assign mem_wdata = memWdata_q;
  assign rsp_valid = rspValid_q;
  assign rsp_rdata = rspRdata_q;
  assign rsp_err   = rspErr_q;

endmodule

// File: tb/tb_mem_bus_ctrl.sv
// Self-checking bench for mem_bus_ctrl (32-bit address/data, TIMEOUT_CYCLES=4).
// Expected responses are queued when a request is driven and compared when
// the controller raises rsp_valid.
module tb_mem_bus_ctrl;

  typedef struct packed {
    logic [31:0] rdata;
    logic        err;
  } rsp_t;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        flush = 1'b0;
  logic        req_valid = 1'b0;
  logic [31:0] req_addr = '0;
  logic        req_we = 1'b0;
  logic [31:0] req_wdata = '0;
  logic        req_ready;
  logic        rsp_valid;
  logic [31:0] rsp_rdata;
  logic        rsp_err;
  logic        mem_cs;
  logic        mem_we;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic        mem_ready = 1'b0;
  logic [31:0] mem_rdata;

  logic        useModel = 1'b0;
  logic [31:0] rdataDrv = '0;

  int   checks = 0;
  int   failures = 0;
  rsp_t expQ[$];

  // Simple memory: either a fixed data word or an address-derived pattern.
  assign mem_rdata = useModel ? (mem_addr ^ 32'h5A5A_0000) : rdataDrv;

  always #5 clk = ~clk;

  mem_bus_ctrl #(
    .ADDR_WIDTH     (32),
    .DATA_WIDTH     (32),
    .TIMEOUT_CYCLES (4)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .flush     (flush),
    .req_valid (req_valid),
    .req_addr  (req_addr),
    .req_we    (req_we),
    .req_wdata (req_wdata),
    .req_ready (req_ready),
    .rsp_valid (rsp_valid),
    .rsp_rdata (rsp_rdata),
    .rsp_err   (rsp_err),
    .mem_cs    (mem_cs),
    .mem_we    (mem_we),
    .mem_addr  (mem_addr),
    .mem_wdata (mem_wdata),
    .mem_ready (mem_ready),
    .mem_rdata (mem_rdata)
  );

  // Reset values of every output and req_ready release afterwards.
  task automatic test_reset();
    reset = 1'b1;
    repeat (2) @(negedge clk);
    #1;
    checks++; if (req_ready !== 1'b0) begin failures++; $display("[TB] FAIL rst_req_ready got=%b exp=0", req_ready); end
    checks++; if (mem_cs !== 1'b0) begin failures++; $display("[TB] FAIL rst_mem_cs got=%b exp=0", mem_cs); end
    checks++; if (rsp_valid !== 1'b0) begin failures++; $display("[TB] FAIL rst_rsp_valid got=%b exp=0", rsp_valid); end
    checks++; if (rsp_err !== 1'b0 || rsp_rdata !== 32'h0) begin failures++; $display("[TB] FAIL rst_rsp got err=%b data=%h exp 0/0", rsp_err, rsp_rdata); end
    checks++; if (mem_addr !== 32'h0 || mem_wdata !== 32'h0 || mem_we !== 1'b0) begin failures++; $display("[TB] FAIL rst_mem got addr=%h wdata=%h we=%b exp 0", mem_addr, mem_wdata, mem_we); end
    reset = 1'b0;
    @(negedge clk); #1;
    checks++; if (req_ready !== 1'b1) begin failures++; $display("[TB] FAIL rst_release_ready got=%b exp=1", req_ready); end
  endtask

  // Zero-wait reads: one ACCESS cycle and a response two cycles after accept.
  task automatic test_aligned_read();
    logic [31:0] addrs [2];
    logic [31:0] datas [2];
    rsp_t        exp;
    addrs[0] = 32'h0000_0100; datas[0] = 32'hDEAD_BEEF;
    addrs[1] = 32'h0000_03FC; datas[1] = 32'hA5A5_0F0F;
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      useModel = 1'b0; rdataDrv = datas[i]; mem_ready = 1'b1;
      req_valid = 1'b1; req_addr = addrs[i]; req_we = 1'b0; req_wdata = 32'hFFFF_FFFF;
      #1;
      checks++; if (req_ready !== 1'b1) begin failures++; $display("[TB] FAIL rd_ready got=%b exp=1", req_ready); end
      expQ.push_back('{rdata: datas[i], err: 1'b0});
      @(negedge clk); req_valid = 1'b0; #1;
      checks++; if (mem_cs !== 1'b1 || mem_addr !== addrs[i] || mem_we !== 1'b0) begin failures++; $display("[TB] FAIL rd_access got cs=%b addr=%h we=%b exp 1/%h/0", mem_cs, mem_addr, mem_we, addrs[i]); end
      checks++; if (rsp_valid !== 1'b0 || req_ready !== 1'b0) begin failures++; $display("[TB] FAIL rd_early got rsp_valid=%b req_ready=%b exp 0/0", rsp_valid, req_ready); end
      @(negedge clk); #1;
      checks++; if (mem_cs !== 1'b0) begin failures++; $display("[TB] FAIL rd_cs_drop got=%b exp=0", mem_cs); end
      checks++;
      if (rsp_valid !== 1'b1 || expQ.size() == 0) begin
        failures++; $display("[TB] FAIL rd_rsp_valid got=%b exp=1 (queued=%0d)", rsp_valid, expQ.size());
      end else begin
        exp = expQ.pop_front();
        checks++; if (rsp_rdata !== exp.rdata || rsp_err !== exp.err) begin failures++; $display("[TB] FAIL rd_rsp got data=%h err=%b exp %h/%b", rsp_rdata, rsp_err, exp.rdata, exp.err); end
      end
      mem_ready = 1'b0;
      @(negedge clk); #1;
      checks++; if (rsp_valid !== 1'b0 || rsp_rdata !== 32'h0 || req_ready !== 1'b1) begin failures++; $display("[TB] FAIL rd_after got valid=%b data=%h ready=%b exp 0/0/1", rsp_valid, rsp_rdata, req_ready); end
    end
  endtask

  // Write with three wait states: stable memory outputs, response data zero.
  task automatic test_write_wait();
    rsp_t exp;
    @(negedge clk);
    useModel = 1'b0; rdataDrv = 32'hFFFF_FFFF; mem_ready = 1'b0;
    req_valid = 1'b1; req_addr = 32'h0000_0200; req_we = 1'b1; req_wdata = 32'h1234_5678;
    expQ.push_back('{rdata: 32'h0, err: 1'b0});
    for (int c = 1; c <= 4; c++) begin
      @(negedge clk);
      req_valid = 1'b0; req_we = 1'b0; req_wdata = 32'h0;
      #1;
      checks++; if (mem_cs !== 1'b1 || mem_we !== 1'b1 || mem_addr !== 32'h200 || mem_wdata !== 32'h1234_5678) begin failures++; $display("[TB] FAIL wr_hold cycle%0d got cs=%b we=%b addr=%h wdata=%h exp 1/1/200/12345678", c, mem_cs, mem_we, mem_addr, mem_wdata); end
      checks++; if (rsp_valid !== 1'b0) begin failures++; $display("[TB] FAIL wr_early cycle%0d got rsp_valid=%b exp=0", c, rsp_valid); end
      if (c == 4) mem_ready = 1'b1;
    end
    @(negedge clk); mem_ready = 1'b0; #1;
    checks++; if (mem_cs !== 1'b0) begin failures++; $display("[TB] FAIL wr_cs_drop got=%b exp=0", mem_cs); end
    checks++;
    if (rsp_valid !== 1'b1 || expQ.size() == 0) begin
      failures++; $display("[TB] FAIL wr_rsp_valid got=%b exp=1", rsp_valid);
    end else begin
      exp = expQ.pop_front();
      checks++; if (rsp_rdata !== exp.rdata || rsp_err !== exp.err) begin failures++; $display("[TB] FAIL wr_rsp got data=%h err=%b exp %h/%b", rsp_rdata, rsp_err, exp.rdata, exp.err); end
    end
  endtask

  // Misaligned requests error out without memory access; next request follows.
  task automatic test_misaligned();
    logic [31:0] bad [3];
    rsp_t        exp;
    bad[0] = 32'h0000_0102; bad[1] = 32'h0000_0101; bad[2] = 32'h0000_0103;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      useModel = 1'b1; mem_ready = 1'b1;
      req_valid = 1'b1; req_addr = bad[i]; req_we = 1'b0;
      #1;
      checks++; if (req_ready !== 1'b1) begin failures++; $display("[TB] FAIL mis_ready got=%b exp=1", req_ready); end
      expQ.push_back('{rdata: 32'h0, err: 1'b1});
      @(negedge clk); req_valid = 1'b0; #1;
      checks++; if (mem_cs !== 1'b0 || mem_addr !== 32'h0) begin failures++; $display("[TB] FAIL mis_no_access got cs=%b addr=%h exp 0/0", mem_cs, mem_addr); end
      checks++;
      if (rsp_valid !== 1'b1 || expQ.size() == 0) begin
        failures++; $display("[TB] FAIL mis_rsp_valid got=%b exp=1", rsp_valid);
      end else begin
        exp = expQ.pop_front();
        checks++; if (rsp_rdata !== exp.rdata || rsp_err !== exp.err) begin failures++; $display("[TB] FAIL mis_rsp got data=%h err=%b exp %h/%b", rsp_rdata, rsp_err, exp.rdata, exp.err); end
      end
      @(negedge clk);
      req_valid = 1'b1; req_addr = 32'h0000_0104 + 32'(i * 16); req_we = 1'b0;
      #1;
      checks++; if (req_ready !== 1'b1) begin failures++; $display("[TB] FAIL mis_next_ready got=%b exp=1", req_ready); end
      expQ.push_back('{rdata: req_addr ^ 32'h5A5A_0000, err: 1'b0});
      @(negedge clk); req_valid = 1'b0; #1;
      checks++; if (mem_cs !== 1'b1) begin failures++; $display("[TB] FAIL mis_next_cs got=%b exp=1", mem_cs); end
      @(negedge clk); #1;
      checks++;
      if (rsp_valid !== 1'b1 || expQ.size() == 0) begin
        failures++; $display("[TB] FAIL mis_next_valid got=%b exp=1", rsp_valid);
      end else begin
        exp = expQ.pop_front();
        checks++; if (rsp_rdata !== exp.rdata || rsp_err !== exp.err) begin failures++; $display("[TB] FAIL mis_next_rsp got data=%h err=%b exp %h/%b", rsp_rdata, rsp_err, exp.rdata, exp.err); end
      end
      mem_ready = 1'b0;
    end
  endtask

  // Flush mid-access abandons it silently; flush beats a request in IDLE.
  task automatic test_flush();
    @(negedge clk);
    useModel = 1'b0; rdataDrv = 32'h1111_2222; mem_ready = 1'b0;
    req_valid = 1'b1; req_addr = 32'h0000_0300; req_we = 1'b0;
    @(negedge clk); req_valid = 1'b0; #1;
    checks++; if (mem_cs !== 1'b1) begin failures++; $display("[TB] FAIL fl_cs1 got=%b exp=1", mem_cs); end
    @(negedge clk); #1;
    checks++; if (mem_cs !== 1'b1) begin failures++; $display("[TB] FAIL fl_cs2 got=%b exp=1", mem_cs); end
    flush = 1'b1;
    @(negedge clk); flush = 1'b0; #1;
    checks++; if (mem_cs !== 1'b0 || rsp_valid !== 1'b0) begin failures++; $display("[TB] FAIL fl_abort got cs=%b rsp_valid=%b exp 0/0", mem_cs, rsp_valid); end
    checks++; if (req_ready !== 1'b1) begin failures++; $display("[TB] FAIL fl_ready got=%b exp=1", req_ready); end
    mem_ready = 1'b1;
    for (int c = 0; c < 3; c++) begin
      @(negedge clk); #1;
      checks++; if (rsp_valid !== 1'b0 || mem_cs !== 1'b0) begin failures++; $display("[TB] FAIL fl_quiet got rsp_valid=%b cs=%b exp 0/0", rsp_valid, mem_cs); end
    end
    mem_ready = 1'b0;
    @(negedge clk);
    flush = 1'b1; req_valid = 1'b1; req_addr = 32'h0000_0400; req_we = 1'b0;
    #1;
    checks++; if (req_ready !== 1'b0) begin failures++; $display("[TB] FAIL fl_idle_ready got=%b exp=0", req_ready); end
    @(negedge clk); flush = 1'b0; req_valid = 1'b0; #1;
    checks++; if (mem_cs !== 1'b0 || rsp_valid !== 1'b0 || req_ready !== 1'b1) begin failures++; $display("[TB] FAIL fl_idle_noaccept got cs=%b rsp_valid=%b ready=%b exp 0/0/1", mem_cs, rsp_valid, req_ready); end
  endtask

  // Continuous request stream: accepts every 3 cycles, latency 2 each.
  task automatic test_back_to_back();
    logic [31:0] addrs [3];
    int          accCyc[$];
    int          lastAcc = -1;
    int          sent = 0;
    int          got = 0;
    bit          advance = 1'b0;
    int          acc;
    rsp_t        exp;
    addrs[0] = 32'h0000_0800; addrs[1] = 32'h0000_0804; addrs[2] = 32'h0000_0808;
    @(negedge clk);
    useModel = 1'b1; mem_ready = 1'b1;
    req_valid = 1'b1; req_addr = addrs[0]; req_we = 1'b0;
    for (int cyc = 0; cyc < 40 && got < 3; cyc++) begin
      if (cyc > 0) @(negedge clk);
      if (advance) begin
        advance = 1'b0;
        if (sent < 3) req_addr = addrs[sent];
        else req_valid = 1'b0;
      end
      #1;
      if (rsp_valid === 1'b1) begin
        checks++;
        if (expQ.size() == 0 || accCyc.size() == 0) begin
          failures++; $display("[TB] FAIL b2b_unexpected_rsp got data=%h exp none", rsp_rdata);
        end else begin
          exp = expQ.pop_front();
          acc = accCyc.pop_front();
          if (rsp_rdata !== exp.rdata || rsp_err !== exp.err) begin failures++; $display("[TB] FAIL b2b_rsp got data=%h err=%b exp %h/%b", rsp_rdata, rsp_err, exp.rdata, exp.err); end
          checks++; if (cyc - acc != 2) begin failures++; $display("[TB] FAIL b2b_latency got=%0d exp=2", cyc - acc); end
        end
        got++;
      end
      if (req_valid && req_ready === 1'b1) begin
        if (lastAcc >= 0) begin
          checks++; if (cyc - lastAcc != 3) begin failures++; $display("[TB] FAIL b2b_interval got=%0d exp=3", cyc - lastAcc); end
        end
        lastAcc = cyc;
        accCyc.push_back(cyc);
        expQ.push_back('{rdata: req_addr ^ 32'h5A5A_0000, err: 1'b0});
        sent++;
        advance = 1'b1;
      end
    end
    req_valid = 1'b0;
    mem_ready = 1'b0;
    checks++; if (got != 3) begin failures++; $display("[TB] FAIL b2b_count got=%0d exp=3", got); end
  endtask

`ifdef MEM_BUS_TIMEOUT_EN
  // Unanswered access aborts after 4 cycles; ready in the 4th cycle wins.
  task automatic test_timeout();
    int   csCount;
    bit   seen;
    rsp_t exp;
    for (int pass = 0; pass < 2; pass++) begin
      @(negedge clk);
      useModel = 1'b0; rdataDrv = 32'h7777_8888; mem_ready = 1'b0;
      req_valid = 1'b1; req_addr = 32'h0000_0500; req_we = 1'b0;
      if (pass == 0) expQ.push_back('{rdata: 32'h0, err: 1'b1});
      else expQ.push_back('{rdata: 32'h7777_8888, err: 1'b0});
      csCount = 0;
      seen = 1'b0;
      for (int c = 1; c <= 12 && !seen; c++) begin
        @(negedge clk);
        req_valid = 1'b0;
        #1;
        if (mem_cs === 1'b1) csCount++;
        if (rsp_valid === 1'b1) begin
          seen = 1'b1;
          checks++;
          if (expQ.size() == 0) begin
            failures++; $display("[TB] FAIL to_unexpected_rsp pass%0d", pass);
          end else begin
            exp = expQ.pop_front();
            if (rsp_rdata !== exp.rdata || rsp_err !== exp.err) begin failures++; $display("[TB] FAIL to_rsp pass%0d got data=%h err=%b exp %h/%b", pass, rsp_rdata, rsp_err, exp.rdata, exp.err); end
          end
          checks++; if (c != 5) begin failures++; $display("[TB] FAIL to_latency pass%0d got=%0d exp=5", pass, c); end
        end
        mem_ready = (pass == 1 && c == 4) ? 1'b1 : 1'b0;
      end
      mem_ready = 1'b0;
      checks++; if (!seen) begin failures++; $display("[TB] FAIL to_no_rsp pass%0d got none exp rsp_valid", pass); end
      checks++; if (csCount != 4) begin failures++; $display("[TB] FAIL to_cs_cycles pass%0d got=%0d exp=4", pass, csCount); end
    end
  endtask
`endif

  // Async reset mid-access clears outputs at once; a fresh read then works.
  task automatic test_reset_mid();
    rsp_t exp;
    @(negedge clk);
    useModel = 1'b1; mem_ready = 1'b0;
    req_valid = 1'b1; req_addr = 32'h0000_0600; req_we = 1'b0;
    @(negedge clk); req_valid = 1'b0; #1;
    checks++; if (mem_cs !== 1'b1) begin failures++; $display("[TB] FAIL rm_cs got=%b exp=1", mem_cs); end
    #2 reset = 1'b1;
    #1;
    checks++; if (mem_cs !== 1'b0 || rsp_valid !== 1'b0 || req_ready !== 1'b0) begin failures++; $display("[TB] FAIL rm_async got cs=%b rsp_valid=%b ready=%b exp 0/0/0", mem_cs, rsp_valid, req_ready); end
    @(negedge clk); reset = 1'b0; #1;
    checks++; if (req_ready !== 1'b1) begin failures++; $display("[TB] FAIL rm_ready got=%b exp=1", req_ready); end
    mem_ready = 1'b1;
    req_valid = 1'b1; req_addr = 32'h0000_0700; req_we = 1'b0;
    expQ.push_back('{rdata: 32'h0000_0700 ^ 32'h5A5A_0000, err: 1'b0});
    @(negedge clk); req_valid = 1'b0; #1;
    checks++; if (mem_cs !== 1'b1 || mem_addr !== 32'h700) begin failures++; $display("[TB] FAIL rm_fresh_cs got cs=%b addr=%h exp 1/700", mem_cs, mem_addr); end
    @(negedge clk); #1;
    checks++;
    if (rsp_valid !== 1'b1 || expQ.size() == 0) begin
      failures++; $display("[TB] FAIL rm_fresh_valid got=%b exp=1", rsp_valid);
    end else begin
      exp = expQ.pop_front();
      checks++; if (rsp_rdata !== exp.rdata || rsp_err !== exp.err) begin failures++; $display("[TB] FAIL rm_fresh_rsp got data=%h err=%b exp %h/%b", rsp_rdata, rsp_err, exp.rdata, exp.err); end
    end
    mem_ready = 1'b0;
  endtask

  initial begin
    test_reset();
    test_aligned_read();
    test_write_wait();
    test_misaligned();
    test_flush();
    test_back_to_back();
`ifdef MEM_BUS_TIMEOUT_EN
    test_timeout();
`endif
    test_reset_mid();
    checks++; if (expQ.size() != 0) begin failures++; $display("[TB] FAIL scoreboard_leftover got=%0d exp=0", expQ.size()); end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog expired before the test sequence completed");
    $fatal(1, "[TB] watchdog");
  end

endmodule
